ref_window_loader: RTL and testbench
====================================

# ref_window_loader

Packs a raw reference-pixel stream into the 15x15 window that `subpixel_interpolation` consumes on `in_buffer`. It is the writer side of that 1800-bit interface. Beats of 8 pixels arrive over a valid/ready stream from the frame-memory fetcher. Complete windows are held in a ping-pong pair of banks, so the next window loads while the interpolator works on the current one.

## Interface
- PIXEL_BITS, 8, bits per pixel
- WIN_DIM, 15, window rows and columns (8x8 block plus 7 filter taps)
- BEAT_PIXELS, 8, pixels per input beat
- Derived constants:
  - BEATS_PER_ROW = ceil(WIN_DIM/BEAT_PIXELS) = 2
  - BEATS_PER_WIN = 30
  - WIN_BITS = 1800

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  64  pixel c of the beat at [c*8 +: 8]
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  marks the final beat of a window
- win_buffer  out  1800  pixel (r,c) at [(r*15+c)*8 +: 8]
- win_valid  out  1  win_buffer holds a complete window
- win_ack  in  1  consumer has taken the window; ignored when win_valid=0
- err_framing  out  1  one-cycle pulse on a framing error

## Operation
- Beat order is row-major, two beats per row.
  - Beat 2r carries columns 0..7.
  - Beat 2r+1 carries columns 8..14 in bytes 0..6. Byte 7 is discarded.
- State:
  - two 1800-bit banks
  - bank_full[1:0]
  - wr_bank, rd_bank
  - beat_cnt 0..29
  - FSM {FILL, RESYNC}
- FILL:
  - in_ready = !bank_full[wr_bank].
  - An accepted beat writes its pixels into bank[wr_bank] and increments beat_cnt.
- Accepted beat with beat_cnt=29 and in_last=1:
  - bank_full[wr_bank] set
  - wr_bank toggles
  - beat_cnt cleared
- Early in_last (accepted with beat_cnt<29):
  - err_framing pulses
  - the partial bank is discarded (bank_full unchanged)
  - beat_cnt cleared, FSM stays in FILL
- Beat 29 accepted with in_last=0:
  - err_framing pulses
  - the partial bank is discarded and beat_cnt cleared
  - FSM goes to RESYNC
- RESYNC:
  - in_ready=1
  - beats are dropped without writing
  - an accepted beat with in_last=1 returns the FSM to FILL with beat_cnt=0
- Read side:
  - win_valid = bank_full[rd_bank]
  - win_buffer = bank[rd_bank]
  - win_ack while win_valid clears bank_full[rd_bank] and toggles rd_bank.
- Completion and ack in the same cycle always target different banks. Both take effect.
- No combinational path from win_ack or in_valid to in_ready. in_ready depends only on registered state.

## Timing
- Reset values:
  - in_ready=0 while rst=1, 1 in the first cycle after release
  - win_valid=0
  - err_framing=0
  - both banks zeroed, win_buffer=0
  - wr_bank=rd_bank=0, beat_cnt=0, FSM=FILL
- Reset mid-window discards everything in flight, including full banks.
- Latency:
  - Final beat accepted at edge N: win_valid=1 after edge N if that bank becomes rd_bank's full bank.
  - err_framing is high for exactly the cycle after the offending edge.
- Throughput: 1 beat/cycle. One window per 30 cycles, with no bubbles if each window is acked within 30 cycles of win_valid.
- Both banks full: in_ready=0. The cycle after win_ack, in_ready=1.
- win_buffer is stable while win_valid=1 and no win_ack.

## Test plan
- Single window:
  - Stimulus: pixel(r,c)=(r*15+c) mod 256, byte 7 of odd beats=0xFF, in_last on beat 29.
  - Response: win_valid=1 one cycle after the last beat; win_buffer[(r*15+c)*8 +: 8]=(r*15+c) mod 256 for all r,c; no 0xFF leaks.
- Backpressure:
  - Stimulus: three windows streamed, no ack.
  - Response: in_ready=0 after the second window completes.
  - Stimulus: ack at cycle T.
  - Response: win_buffer switches to window 2 at T+1; in_ready=1 at T+1; window 3 then loads.
- Early in_last:
  - Stimulus: in_last on beat 10.
  - Response: err_framing pulse, no win_valid; the next 30 well-formed beats yield a correct window.
- Missing in_last:
  - Stimulus: beat 29 without in_last, then 5 junk beats, the 5th with in_last.
  - Response: err_framing pulses once, junk is dropped, the following window is correct.
- Simultaneous events:
  - Stimulus: win_ack on the same edge as completion of the other bank.
  - Response: win_valid stays 1 and win_buffer switches to the new window.
- Reset mid-window:
  - Stimulus: rst at beat 15 with one bank full.
  - Response: win_valid=0, win_buffer=0; a fresh 30-beat window then completes normally.

Source files
------------

// File: rtl/ref_window_loader.sv
// Packs 8-pixel beats into a 15x15 reference window held in a ping-pong pair of banks,
// presenting the completed window on win_buffer until the consumer acks it.
module ref_window_loader #(
    parameter int PIXEL_BITS  = 8,
    parameter int WIN_DIM     = 15,
    parameter int BEAT_PIXELS = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [BEAT_PIXELS*PIXEL_BITS-1:0]   in_data,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                in_last,
    output logic [WIN_DIM*WIN_DIM*PIXEL_BITS-1:0] win_buffer,
    output logic                                win_valid,
    input  logic                                win_ack,
    output logic                                err_framing
);

    localparam int BEATS_PER_ROW = (WIN_DIM + BEAT_PIXELS - 1) / BEAT_PIXELS;
    localparam int BEATS_PER_WIN = WIN_DIM * BEATS_PER_ROW;
    localparam int WIN_BITS      = WIN_DIM * WIN_DIM * PIXEL_BITS;
    localparam int CNT_W         = $clog2(BEATS_PER_WIN);

    localparam logic [0:0] FILL   = 1'b0;
    localparam logic [0:0] RESYNC = 1'b1;

    logic [WIN_BITS-1:0] bank [2];
    logic [1:0]          bank_full;
    logic [1:0]          bank_full_next;
    logic                wr_bank;
    logic                rd_bank;
    logic [CNT_W-1:0]    beat_cnt;
    logic [0:0]          state;

    logic accept;
    logic do_write;
    logic last_beat;
    logic complete;
    logic take;
    int   row;
    int   col_base;

    // in_ready looks only at registered state (and rst), never at in_valid or win_ack.
    assign in_ready   = !rst && ((state == RESYNC) || !bank_full[wr_bank]);
    assign accept     = in_valid && in_ready;
    assign do_write   = accept && (state == FILL);
    assign last_beat  = (beat_cnt == CNT_W'(BEATS_PER_WIN - 1));
    assign complete   = do_write && last_beat && in_last;
    assign take       = win_ack && win_valid;

    assign win_valid  = bank_full[rd_bank];
    assign win_buffer = bank[rd_bank];

    always_comb begin
        row      = int'(beat_cnt) / BEATS_PER_ROW;
        col_base = (int'(beat_cnt) % BEATS_PER_ROW) * BEAT_PIXELS;
    end

    // Completion always targets the empty write bank and an ack the full read bank,
    // so both updates can land in the same cycle without conflict.
    always_comb begin
        bank_full_next = bank_full;
        if (complete) bank_full_next[wr_bank] = 1'b1;
        if (take)     bank_full_next[rd_bank] = 1'b0;
    end

    // NOTE: the banks are reset on purpose: win_buffer must read as all-zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank[0] <= '0;
            bank[1] <= '0;
        end else if (do_write) begin
            for (int c = 0; c < BEAT_PIXELS; c++) begin
                if (col_base + c < WIN_DIM) begin
                    bank[wr_bank][(row * WIN_DIM + col_base + c) * PIXEL_BITS +: PIXEL_BITS]
                        <= in_data[c * PIXEL_BITS +: PIXEL_BITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full   <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            beat_cnt    <= '0;
            state       <= FILL;
            err_framing <= 1'b0;
        end else begin
            err_framing <= 1'b0;
            bank_full   <= bank_full_next;
            if (take) rd_bank <= ~rd_bank;

            if (accept) begin
                if (state == FILL) begin
                    if (last_beat) begin
                        beat_cnt <= '0;
                        if (in_last) begin
                            wr_bank <= ~wr_bank;
                        end else begin
                            err_framing <= 1'b1;
                            state       <= RESYNC;
                        end
                    end else if (in_last) begin
                        // Short window: drop it, stay aligned on the next beat.
                        beat_cnt    <= '0;
                        err_framing <= 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end else if (in_last) begin
                    state <= FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_ref_window_loader.sv
// Scoreboard bench for ref_window_loader: the driver queues each expected window,
// a negedge monitor compares it when the consumer acks.
module tb_ref_window_loader;

    localparam int WIN_BITS = 1800;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [63:0]         in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic                in_last = 1'b0;
    logic [WIN_BITS-1:0] win_buffer;
    logic                win_valid;
    logic                win_ack = 1'b0;
    logic                err_framing;

    int n_tests  = 0;
    int n_fail   = 0;
    int err_seen = 0;
    logic [WIN_BITS-1:0] exp_q [$];

    ref_window_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .win_buffer (win_buffer),
        .win_valid  (win_valid),
        .win_ack    (win_ack),
        .err_framing(err_framing)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix(int s, int idx);
        return 8'((idx + s) % 256);
    endfunction

    // Beat b of window seed s: even beats carry columns 0..7, odd beats 8..14 plus a 0xFF pad.
    function automatic logic [63:0] make_beat(int s, int b);
        logic [63:0] v;
        int r    = b / 2;
        int base = (b % 2) * 8;
        for (int k = 0; k < 8; k++) begin
            if (base + k < 15) v[k*8 +: 8] = pix(s, r * 15 + base + k);
            else               v[k*8 +: 8] = 8'hFF;
        end
        return v;
    endfunction

    function automatic logic [WIN_BITS-1:0] make_win(int s);
        logic [WIN_BITS-1:0] w;
        for (int i = 0; i < 225; i++) w[i*8 +: 8] = pix(s, i);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reports the first differing pixel, or compares pixel 0 when the windows agree.
    task automatic check_win(input string name, input logic [WIN_BITS-1:0] got,
                             input logic [WIN_BITS-1:0] exp);
        int idx = 0;
        for (int i = 224; i >= 0; i--) begin
            if (got[i*8 +: 8] !== exp[i*8 +: 8]) idx = i;
        end
        check($sformatf("%s[pix %0d]", name, idx), 64'(got[idx*8 +: 8]), 64'(exp[idx*8 +: 8]));
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_beat(input logic [63:0] data, input logic last);
        int waited = 0;
        in_data  = data;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            waited++;
            if (waited > 200) begin
                check("beat_accept_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_beats(input int s, input int from, input int to, input logic last_on_to);
        for (int b = from; b <= to; b++) send_beat(make_beat(s, b), last_on_to && (b == to));
    endtask

    task automatic send_window(input int s);
        exp_q.push_back(make_win(s));
        send_beats(s, 0, 29, 1'b1);
    endtask

    task automatic ack_once();
        int w = 0;
        win_ack = 1'b1;
        @(negedge clk);
        while (!win_valid && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!win_valid) check("ack_wait_timeout", 64'(win_valid), 64'd1);
        @(posedge clk);
        #1;
        win_ack = 1'b0;
    endtask

    // Monitor: consumes a queued window on every ack handshake and checks hold stability.
    initial begin
        logic [WIN_BITS-1:0] prev_buf = '0;
        logic prev_valid = 1'b0;
        logic prev_ack   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_ack   = 1'b0;
            end else begin
                if (err_framing) err_seen++;
                if (win_valid && prev_valid && !prev_ack)
                    check_win("hold_stable", win_buffer, prev_buf);
                if (win_valid && win_ack) begin
                    if (exp_q.size() == 0) check("unexpected_window", 64'd1, 64'd0);
                    else                   check_win("window_data", win_buffer, exp_q.pop_front());
                end
                prev_valid = win_valid;
                prev_ack   = win_ack;
                prev_buf   = win_buffer;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   64'(in_ready),    64'd0);
        check("rst_win_valid",  64'(win_valid),   64'd0);
        check("rst_err",        64'(err_framing), 64'd0);
        check("rst_win_buffer", 64'(|win_buffer), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single window, valid exactly after the last beat
        exp_q.push_back(make_win(0));
        send_beats(0, 0, 28, 1'b0);
        check("single_no_early_valid", 64'(win_valid), 64'd0);
        send_beats(0, 29, 29, 1'b1);
        check("single_valid_latency", 64'(win_valid), 64'd1);
        ack_once();

        // Backpressure: two full banks stall the third window until an ack
        send_window(1);
        send_window(2);
        @(negedge clk);
        check("bp_ready_low", 64'(in_ready),  64'd0);
        check("bp_valid",     64'(win_valid), 64'd1);
        @(posedge clk);
        #1;
        fork
            send_window(3);
            begin
                repeat (4) @(posedge clk);
                #1;
                check("bp_still_stalled", 64'(in_ready), 64'd0);
                ack_once();
                @(negedge clk);
                check_win("bp_switch", win_buffer, make_win(2));
                check("bp_ready_after_ack", 64'(in_ready), 64'd1);
            end
        join
        ack_once();
        ack_once();

        // Early in_last on beat 10
        send_beats(4, 0, 10, 1'b1);
        check("early_err_pulse", 64'(err_framing), 64'd1);
        check("early_no_valid",  64'(win_valid),   64'd0);
        @(posedge clk);
        #1;
        check("early_err_one_cycle", 64'(err_framing), 64'd0);
        send_window(5);
        ack_once();

        // Missing in_last on beat 29, then five junk beats
        send_beats(6, 0, 29, 1'b0);
        check("missing_err_pulse", 64'(err_framing), 64'd1);
        for (int k = 0; k < 5; k++) send_beat(64'hA5C3_5A3C_0F1E_2D4B, k == 4);
        check("junk_no_valid", 64'(win_valid), 64'd0);
        check("junk_ready",    64'(in_ready),  64'd1);
        send_window(7);
        ack_once();

        // Ack on the same edge that completes the other bank
        send_window(8);
        exp_q.push_back(make_win(9));
        send_beats(9, 0, 28, 1'b0);
        fork
            send_beat(make_beat(9, 29), 1'b1);
            begin
                win_ack = 1'b1;
                @(posedge clk);
                #1;
                win_ack = 1'b0;
            end
        join
        @(negedge clk);
        check("simul_valid", 64'(win_valid), 64'd1);
        check_win("simul_switch", win_buffer, make_win(9));
        @(posedge clk);
        #1;
        ack_once();

        // Reset mid-window with one bank full
        send_window(10);
        send_beats(11, 0, 14, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("midrst_ready",      64'(in_ready),    64'd0);
        check("midrst_win_valid",  64'(win_valid),   64'd0);
        check("midrst_win_buffer", 64'(|win_buffer), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        send_window(12);
        check("post_rst_valid", 64'(win_valid), 64'd1);
        ack_once();

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("err_total",     64'(err_seen),     64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
